tpm_port_scheduler: RTL and testbench

//   Round-robin scheduler sharing one single-port memory macro among three requester ports.

---
 rtl/tpm_port_scheduler.sv | 152 +++++++++++++++
 tb/tb_tpm_port_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpm_port_scheduler.sv
// -----------------------------------------------------------------------------
// tpm_port_scheduler
//   Shares one single-port memory macro among three requester ports. A
//   round-robin arbiter grants at most one request per cycle and drives the
//   memory port in the same cycle. Each accepted read is tagged with its port
//   and the tag travels down an RD_LAT-deep pipeline, so the read data coming
//   back from the macro is steered to the port that asked for it.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   hold          1 = no grants this cycle (tag pipeline keeps moving)
//   req_valid     per-port request valid (bit k = port k)
//   req_we        per-port write enable (1 = write, 0 = read)
//   req_addr      per-port address, port k at [k*AW +: AW]
//   req_wdata     per-port write data, port k at [k*DW +: DW]
//   req_ready     per-port accept strobe, one-hot or zero
//   rsp_valid     per-port read-data valid, one-hot or zero
//   rsp_rdata     read data for the port flagged in rsp_valid, else 0
//   mem_en/we/addr/wdata  memory macro request, all 0 when idle
//   mem_rdata     memory read data, valid RD_LAT cycles after a read
//   rd_inflight   number of accepted reads not yet returned (0..RD_LAT)
//
// Handshake: a request transfers on a rising clock edge when req_valid[k]
// and req_ready[k] are both 1. A requester keeps we/addr/wdata stable while
// valid is high and ready is low, and valid never depends combinationally on
// ready. req_ready is driven combinationally from req_valid, hold, reset and
// the priority pointer.
// -----------------------------------------------------------------------------
module tpm_port_scheduler #(
    parameter int DW     = 8,
    parameter int AW     = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [2:0]        req_valid,
    input  logic [2:0]        req_we,
    input  logic [3*AW-1:0]   req_addr,
    input  logic [3*DW-1:0]   req_wdata,
    output logic [2:0]        req_ready,
    output logic [2:0]        rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [2:0]        rd_inflight
);

    // Highest-priority port this cycle; only ever holds 0, 1 or 2.
    logic [1:0] rr_ptr;

    logic       gnt_any;
    logic [1:0] gnt_port;
    logic [1:0] cand;

    // Read tag pipeline: stage 0 is loaded at the grant edge, the last stage
    // lines up with mem_rdata.
    logic [RD_LAT-1:0] tag_v;
    logic [1:0]        tag_p [RD_LAT];

    // (base + off) mod 3 for base, off in 0..2
    function automatic logic [1:0] port_at(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Arbiter: first valid port in the order rr_ptr, rr_ptr+1, rr_ptr+2.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_port = 2'd0;
        cand     = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cand = port_at(rr_ptr, 2'(i));
            if (!gnt_any && req_valid[cand]) begin
                gnt_any  = 1'b1;
                gnt_port = cand;
            end
        end
        if (hold || reset) begin
            gnt_any  = 1'b0;
            gnt_port = 2'd0;
        end
    end

    assign req_ready = gnt_any ? (3'b001 << gnt_port) : 3'b000;

    // Memory drive from the granted port, all zero when nothing is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_any) begin
            mem_en    = 1'b1;
            mem_we    = req_we[gnt_port];
            mem_addr  = req_addr[gnt_port*AW +: AW];
            mem_wdata = req_wdata[gnt_port*DW +: DW];
        end
    end

    // The port after the winner becomes the highest priority next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 2'd0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_port == 2'd2) ? 2'd0 : gnt_port + 2'd1;
        end
    end

    // Tags shift every cycle regardless of hold; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_p[i] <= 2'd0;
            end
        end else begin
            tag_v[0] <= gnt_any & ~mem_we;
            tag_p[0] <= gnt_port;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    // Response steering; forced quiet while reset is asserted, even in the
    // cycle before the clearing edge.
    always_comb begin
        rsp_valid = 3'b000;
        rsp_rdata = '0;
        if (tag_v[RD_LAT-1] && !reset) begin
            rsp_valid = 3'b001 << tag_p[RD_LAT-1];
            rsp_rdata = mem_rdata;
        end
    end

    always_comb begin
        rd_inflight = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            rd_inflight = rd_inflight + {2'b00, tag_v[i]};
        end
    end

endmodule

// File: tb/tb_tpm_port_scheduler.sv
module tb_tpm_port_scheduler;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int W  = 28;  // {inst, cycle[15:0], port one-hot[2:0], data[7:0]}

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // DUT with RD_LAT=1
  // ---------------------------------------------------------------------------
  logic            hold_l1 = 1'b0;
  logic [2:0]      req_valid_l1 = '0, req_we_l1 = '0;
  logic [3*AW-1:0] req_addr_l1 = '0;
  logic [3*DW-1:0] req_wdata_l1 = '0;
  logic [2:0]      req_ready_l1, rsp_valid_l1, rd_inflight_l1;
  logic [DW-1:0]   rsp_rdata_l1, mem_wdata_l1, mem_rdata_l1;
  logic            mem_en_l1, mem_we_l1;
  logic [AW-1:0]   mem_addr_l1;

  tpm_port_scheduler #(.DW(DW), .AW(AW), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .hold(hold_l1),
    .req_valid(req_valid_l1), .req_we(req_we_l1), .req_addr(req_addr_l1),
    .req_wdata(req_wdata_l1), .req_ready(req_ready_l1),
    .rsp_valid(rsp_valid_l1), .rsp_rdata(rsp_rdata_l1),
    .mem_en(mem_en_l1), .mem_we(mem_we_l1), .mem_addr(mem_addr_l1),
    .mem_wdata(mem_wdata_l1), .mem_rdata(mem_rdata_l1),
    .rd_inflight(rd_inflight_l1)
  );

  // ---------------------------------------------------------------------------
  // DUT with RD_LAT=3
  // ---------------------------------------------------------------------------
  logic            hold_l3 = 1'b0;
  logic [2:0]      req_valid_l3 = '0, req_we_l3 = '0;
  logic [3*AW-1:0] req_addr_l3 = '0;
  logic [3*DW-1:0] req_wdata_l3 = '0;
  logic [2:0]      req_ready_l3, rsp_valid_l3, rd_inflight_l3;
  logic [DW-1:0]   rsp_rdata_l3, mem_wdata_l3, mem_rdata_l3;
  logic            mem_en_l3, mem_we_l3;
  logic [AW-1:0]   mem_addr_l3;

  tpm_port_scheduler #(.DW(DW), .AW(AW), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .hold(hold_l3),
    .req_valid(req_valid_l3), .req_we(req_we_l3), .req_addr(req_addr_l3),
    .req_wdata(req_wdata_l3), .req_ready(req_ready_l3),
    .rsp_valid(rsp_valid_l3), .rsp_rdata(rsp_rdata_l3),
    .mem_en(mem_en_l3), .mem_we(mem_we_l3), .mem_addr(mem_addr_l3),
    .mem_wdata(mem_wdata_l3), .mem_rdata(mem_rdata_l3),
    .rd_inflight(rd_inflight_l3)
  );

  // ---------------------------------------------------------------------------
  // memory macro models, preloaded with 0x40 + address
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram_l1 [64];
  logic [DW-1:0] ram_l3 [64];
  logic [DW-1:0] rd_l1 = '0;
  logic [DW-1:0] rd_l3 [3];

  initial begin
    for (int a = 0; a < 64; a++) begin
      ram_l1[a] = 8'(8'h40 + a);
      ram_l3[a] = 8'(8'h40 + a);
    end
    for (int s = 0; s < 3; s++) rd_l3[s] = '0;
  end

  always @(posedge clk) begin
    if (mem_en_l1) begin
      if (mem_we_l1) ram_l1[mem_addr_l1] <= mem_wdata_l1;
      else           rd_l1 <= ram_l1[mem_addr_l1];
    end
    if (mem_en_l3 && mem_we_l3) ram_l3[mem_addr_l3] <= mem_wdata_l3;
    rd_l3[0] <= (mem_en_l3 && !mem_we_l3) ? ram_l3[mem_addr_l3] : 8'h00;
    rd_l3[1] <= rd_l3[0];
    rd_l3[2] <= rd_l3[1];
  end

  assign mem_rdata_l1 = rd_l1;
  assign mem_rdata_l3 = rd_l3[2];

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hold_l1 = 1'b0; req_valid_l1 = '0; req_we_l1 = '0; req_addr_l1 = '0; req_wdata_l1 = '0;
    hold_l3 = 1'b0; req_valid_l3 = '0; req_we_l3 = '0; req_addr_l3 = '0; req_wdata_l3 = '0;
  endtask

  // One clock cycle of stimulus on instance sel (0: RD_LAT=1, 1: RD_LAT=3).
  // exp_rdy is the hand-computed grant; a granted read with keep=1 pushes
  // its expected response (cycle, port, data) onto the scoreboard.
  task automatic step(input bit sel, input bit h, input logic [2:0] v, input logic [2:0] we,
                      input logic [3*AW-1:0] a, input logic [3*DW-1:0] wd,
                      input logic [2:0] exp_rdy, input logic [DW-1:0] exp_rd, input bit keep);
    int g;
    int lat;
    logic [2:0]  rdy;
    logic [15:0] mem_act, mem_exp;
    @(posedge clk); #1;
    idle_inputs();
    if (sel == 1'b0) begin
      hold_l1 = h; req_valid_l1 = v; req_we_l1 = we; req_addr_l1 = a; req_wdata_l1 = wd;
    end else begin
      hold_l3 = h; req_valid_l3 = v; req_we_l3 = we; req_addr_l3 = a; req_wdata_l3 = wd;
    end
    @(negedge clk);
    if (sel == 1'b0) begin
      rdy = req_ready_l1;
      mem_act = {mem_en_l1, mem_we_l1, mem_addr_l1, mem_wdata_l1};
    end else begin
      rdy = req_ready_l3;
      mem_act = {mem_en_l3, mem_we_l3, mem_addr_l3, mem_wdata_l3};
    end
    chk("req_ready", {29'd0, rdy}, {29'd0, exp_rdy});
    g = exp_rdy[0] ? 0 : (exp_rdy[1] ? 1 : 2);
    if (exp_rdy == 3'b000) mem_exp = 16'h0000;
    else mem_exp = {1'b1, we[g], a[g*AW +: AW], wd[g*DW +: DW]};
    chk("mem_port", {16'd0, mem_act}, {16'd0, mem_exp});
    lat = sel ? 3 : 1;
    if (exp_rdy != 3'b000 && !we[g] && keep)
      exp_q.push_back({sel, 16'(cyc + lat), exp_rdy, exp_rd});
  endtask

  // ---------------------------------------------------------------------------
  // scoreboard monitor
  // ---------------------------------------------------------------------------
  task automatic mon_port(input bit sel, input logic [2:0] rv, input logic [DW-1:0] rd);
    logic [W-1:0] e;
    checks++;
    if (rv != 3'b000) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected inst %0d cycle %0d: got valid %b data %0h expected none", sel, cyc, rv, rd);
      end else begin
        e = exp_q.pop_front();
        if (e[27] !== sel || e[26:11] !== 16'(cyc) || e[10:8] !== rv || e[7:0] !== rd) begin
          errors++;
          $display("FAIL rsp inst %0d cycle %0d: got valid %b data %0h expected inst %0d cycle %0d valid %b data %0h",
                   sel, cyc, rv, rd, e[27], e[26:11], e[10:8], e[7:0]);
        end
      end
    end else if (rd != '0) begin
      errors++;
      $display("FAIL rsp_rdata_idle inst %0d cycle %0d: got %0h expected 0", sel, cyc, rd);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0][26:11] < 16'(cyc)) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing cycle %0d: got nothing expected inst %0d cycle %0d valid %b data %0h",
                 cyc, exp_q[0][27], exp_q[0][26:11], exp_q[0][10:8], exp_q[0][7:0]);
        void'(exp_q.pop_front());
      end
      mon_port(1'b0, rsp_valid_l1, rsp_rdata_l1);
      mon_port(1'b1, rsp_valid_l3, rsp_rdata_l3);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // directed stimulus
  // ---------------------------------------------------------------------------
  localparam logic [3*AW-1:0] A123 = {6'd3, 6'd2, 6'd1};

  initial begin
    // reset with every port of both instances requesting
    reset = 1'b1;
    idle_inputs();
    req_valid_l1 = 3'b111; req_addr_l1 = A123;
    req_valid_l3 = 3'b111; req_addr_l3 = A123;
    @(posedge clk);
    @(negedge clk);
    chk("reset_ready_l1", {29'd0, req_ready_l1}, 32'd0);
    chk("reset_mem_en_l1", {31'd0, mem_en_l1}, 32'd0);
    chk("reset_rsp_valid_l1", {29'd0, rsp_valid_l1}, 32'd0);
    chk("reset_rsp_rdata_l1", {24'd0, rsp_rdata_l1}, 32'd0);
    chk("reset_inflight_l1", {29'd0, rd_inflight_l1}, 32'd0);
    chk("reset_inflight_l3", {29'd0, rd_inflight_l3}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    mon_en = 1'b1;

    // all three ports read addr 1,2,3 every cycle: 0,1,2,0,1,2
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b001, 8'h41, 1);
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b010, 8'h42, 1);
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b100, 8'h43, 1);
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b001, 8'h41, 1);
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b010, 8'h42, 1);
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b100, 8'h43, 1);
    step(0, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);

    // port 2 alone: write 0xA5 to addr 5, then read it back
    step(0, 0, 3'b100, 3'b100, {6'd5, 6'd0, 6'd0}, {8'hA5, 8'h00, 8'h00}, 3'b100, 8'h00, 1);
    step(0, 0, 3'b100, 3'b000, {6'd5, 6'd0, 6'd0}, '0, 3'b100, 8'hA5, 1);

    // rr_ptr back at 0: port 0 wins, then hold for 4 cycles
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b001, 8'h41, 1);
    for (int i = 0; i < 4; i++)
      step(0, 1, 3'b111, 3'b000, A123, '0, 3'b000, 8'h00, 1);
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b010, 8'h42, 1);
    step(0, 0, 3'b111, 3'b000, A123, '0, 3'b100, 8'h43, 1);
    step(0, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);

    // ports 0 and 1 contend: strict alternation
    step(0, 0, 3'b011, 3'b000, A123, '0, 3'b001, 8'h41, 1);
    step(0, 0, 3'b011, 3'b000, A123, '0, 3'b010, 8'h42, 1);
    step(0, 0, 3'b011, 3'b000, A123, '0, 3'b001, 8'h41, 1);
    step(0, 0, 3'b011, 3'b000, A123, '0, 3'b010, 8'h42, 1);
    step(0, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);

    // read addr 7 then write addr 7 next cycle: read sees old data
    step(0, 0, 3'b001, 3'b000, {6'd0, 6'd0, 6'd7}, '0, 3'b001, 8'h47, 1);
    step(0, 0, 3'b010, 3'b010, {6'd0, 6'd7, 6'd0}, {8'h00, 8'h99, 8'h00}, 3'b010, 8'h00, 1);
    step(0, 0, 3'b001, 3'b000, {6'd0, 6'd0, 6'd7}, '0, 3'b001, 8'h99, 1);
    step(0, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);

    // RD_LAT=3: port 1 reads addr 10,11,12 back to back
    step(1, 0, 3'b010, 3'b000, {6'd0, 6'd10, 6'd0}, '0, 3'b010, 8'h4A, 1);
    chk("inflight_l3_0", {29'd0, rd_inflight_l3}, 32'd0);
    step(1, 0, 3'b010, 3'b000, {6'd0, 6'd11, 6'd0}, '0, 3'b010, 8'h4B, 1);
    chk("inflight_l3_1", {29'd0, rd_inflight_l3}, 32'd1);
    step(1, 0, 3'b010, 3'b000, {6'd0, 6'd12, 6'd0}, '0, 3'b010, 8'h4C, 1);
    step(1, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);
    chk("inflight_l3_3", {29'd0, rd_inflight_l3}, 32'd3);
    step(1, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);
    chk("inflight_l3_2", {29'd0, rd_inflight_l3}, 32'd2);
    step(1, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);
    step(1, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);
    chk("inflight_l3_drain", {29'd0, rd_inflight_l3}, 32'd0);

    // two reads in flight, then reset: they must never come back
    step(1, 0, 3'b001, 3'b000, {6'd0, 6'd0, 6'd20}, '0, 3'b001, 8'h00, 0);
    step(1, 0, 3'b001, 3'b000, {6'd0, 6'd0, 6'd21}, '0, 3'b001, 8'h00, 0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    req_valid_l3 = 3'b111; req_addr_l3 = A123;
    @(negedge clk);
    chk("inflight_before_reset", {29'd0, rd_inflight_l3}, 32'd2);
    chk("reset_ready_l3", {29'd0, req_ready_l3}, 32'd0);
    chk("reset_mem_en_l3", {31'd0, mem_en_l3}, 32'd0);
    chk("reset_rsp_valid_l3", {29'd0, rsp_valid_l3}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("inflight_after_reset", {29'd0, rd_inflight_l3}, 32'd0);
    chk("rsp_after_reset", {29'd0, rsp_valid_l3}, 32'd0);
    step(1, 0, 3'b111, 3'b000, A123, '0, 3'b001, 8'h41, 1);
    for (int i = 0; i < 5; i++)
      step(1, 0, 3'b000, 3'b000, '0, '0, 3'b000, 8'h00, 1);

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
